// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
// Shared definitions for the register-file dump reader and its neighbours.
//   REG_ADDR_W    : architectural register index width
//   REG_DATA_W    : architectural register data width
//   NUM_ARCH_REGS : number of architectural registers
//   dump_state_e  : dump sequencer states
//   first_addr()  : first swept address, given the skip-r0 option
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned NUM_ARCH_REGS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend,
        StDone
    } dump_state_e;

    // r0 is hard-wired zero, so a sweep may optionally start at r1.
    function automatic int unsigned first_addr(input int unsigned skip_zero);
        return (skip_zero != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
// Sequential reader for the register file. A Start pulse in IDLE walks every
// register address on one combinational read port and streams each value,
// tagged with its index, over a valid/ready channel.
//
// Ports:
//   i_clk           : clock, rising edge
//   i_rst           : asynchronous active-high reset, forces IDLE, outputs 0
//   i_start         : dump request, sampled only in IDLE
//   o_read_register : address driven to the register-file read port
//   i_read_data     : combinational read data for o_read_register
//   o_dump_data     : register value offered
//   o_dump_addr     : index of o_dump_data
//   o_dump_valid    : o_dump_data / o_dump_addr valid
//   i_dump_ready    : consumer accepts when high together with o_dump_valid
//   o_busy          : high from the cycle after Start until DONE exits
//   o_done          : one-cycle pulse after the last register is accepted
// -----------------------------------------------------------------------------
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_ARCH_REGS,
    parameter int unsigned ADDR_W    = REG_ADDR_W,
    parameter int unsigned DATA_W    = REG_DATA_W,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_read_register,
    input  logic [DATA_W-1:0] i_read_data,
    output logic [DATA_W-1:0] o_dump_data,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(first_addr(SKIP_ZERO));
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    dump_state_e       r_state;
    logic [ADDR_W-1:0] r_read_register;
    logic [DATA_W-1:0] r_dump_data;
    logic [ADDR_W-1:0] r_dump_addr;
    logic              r_dump_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_handshake;
    logic              w_last;

    assign w_handshake = r_dump_valid & i_dump_ready;
    // Stopping on the last index keeps the counter from ever wrapping to NUM_REGS.
    assign w_last      = (r_read_register == LAST_ADDR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_read_register <= '0;
            r_dump_data     <= '0;
            r_dump_addr     <= '0;
            r_dump_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_read_register <= FIRST_ADDR;
                        r_busy          <= 1'b1;
                        r_state         <= StFetch;
                    end
                end
                StFetch: begin
                    // Address has been stable for a full cycle; sample the read port.
                    r_dump_data  <= i_read_data;
                    r_dump_addr  <= r_read_register;
                    r_dump_valid <= 1'b1;
                    r_state      <= StSend;
                end
                StSend: begin
                    if (w_handshake) begin
                        r_dump_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_read_register <= r_read_register + ADDR_W'(1);
                            r_state         <= StFetch;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_read_register = r_read_register;
    assign o_dump_data     = r_dump_data;
    assign o_dump_addr     = r_dump_addr;
    assign o_dump_valid    = r_dump_valid;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

    // An offered beat is never withdrawn or altered before it is accepted.
    property p_hold_until_accepted;
        @(posedge i_clk) disable iff (i_rst)
        (o_dump_valid && !i_dump_ready) |=>
            (o_dump_valid && $stable(o_dump_data) && $stable(o_dump_addr));
    endproperty
    a_hold_until_accepted: assert property (p_hold_until_accepted);

    property p_addr_in_range;
        @(posedge i_clk) disable iff (i_rst)
        o_read_register <= LAST_ADDR;
    endproperty
    a_addr_in_range: assert property (p_addr_in_range);

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
// Two readers share one register-file model: dut0 sweeps from r0, dut1 skips
// r0. Stimulus pushes expected beats into per-reader queues; monitors pop and
// compare on every accepted beat.
// -----------------------------------------------------------------------------
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } beat_t;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_BP      = 1;
    localparam int MODE_RESTART = 2;
    localparam int MODE_RESET   = 3;
    localparam int MODE_WRITE   = 4;

    logic        clk;
    logic        rst;
    logic        start0, ready0, valid0, busy0, done0;
    logic [4:0]  rreg0, daddr0;
    logic [31:0] rdata0, ddata0;
    logic        start1, ready1, valid1, busy1, done1;
    logic [4:0]  rreg1, daddr1;
    logic [31:0] rdata1, ddata1;

    logic [31:0] regs     [NUM_ARCH_REGS];
    logic [31:0] exp_regs [NUM_ARCH_REGS];
    logic        rf_init, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    beat_t       q0 [$];
    beat_t       q1 [$];
    beat_t       m0, m1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;
    logic [4:0]  last_addr1 = '0;

    regfile_dump #(.SKIP_ZERO(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0),
        .o_read_register(rreg0), .i_read_data(rdata0),
        .o_dump_data(ddata0), .o_dump_addr(daddr0), .o_dump_valid(valid0),
        .i_dump_ready(ready0), .o_busy(busy0), .o_done(done0)
    );

    regfile_dump #(.SKIP_ZERO(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .o_read_register(rreg1), .i_read_data(rdata1),
        .o_dump_data(ddata1), .o_dump_addr(daddr1), .o_dump_valid(valid1),
        .i_dump_ready(ready1), .o_busy(busy1), .o_done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: synchronous write, combinational reads.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h100 + i;
        end else if (rf_we) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    assign rdata0 = regs[rreg0];
    assign rdata1 = regs[rreg1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (valid0 && ready0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat0_unexpected: got addr %0d data 0x%0h expected none",
                         daddr0, ddata0);
            end else begin
                m0 = q0.pop_front();
                check("beat0_addr", 32'(daddr0), 32'(m0.addr));
                check("beat0_data", ddata0, m0.data);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) done_cnt1++;
        if (valid1 && ready1) begin
            last_addr1 = daddr1;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat1_unexpected: got addr %0d data 0x%0h expected none",
                         daddr1, ddata1);
            end else begin
                m1 = q1.pop_front();
                check("beat1_addr", 32'(daddr1), 32'(m1.addr));
                check("beat1_data", ddata1, m1.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump0(input int mode);
        beat_t b;
        int    e0, done_cyc, dc_before, exp_len;
        bit    seen_valid, seen_done, pulsed, bp_done, wr_done, rst_done;
        seen_valid = 0; seen_done = 0; pulsed = 0; bp_done = 0; wr_done = 0; rst_done = 0;
        done_cyc = 0;
        exp_len = (mode == MODE_BP) ? 67 : 64;
        for (int i = 0; i < 32; i++) begin
            b.addr = 5'(i);
            b.data = exp_regs[i];
            q0.push_back(b);
        end
        dc_before = done_cnt0;
        start0 = 1'b1;
        e0 = cyc + 1;
        for (int n = 0; n < 200 && !seen_done && !rst_done; n++) begin
            tick();
            start0 = 1'b0;
            rf_we  = 1'b0;
            if (n == 0) begin
                check("start_busy", 32'(busy0), 1);
                check("start_rreg", 32'(rreg0), 0);
            end
            if (!seen_valid && valid0) begin
                seen_valid = 1;
                check("first_valid_latency", cyc - e0, 1);
            end
            if (done0) begin
                seen_done = 1;
                done_cyc  = cyc;
                if (mode == MODE_RESTART) start0 = 1'b1;
            end
            if (mode == MODE_RESTART && !pulsed && valid0 && daddr0 == 10) begin
                start0 = 1'b1;
                pulsed = 1;
            end
            // FETCH for r7: write lands on the same edge that samples it.
            if (mode == MODE_WRITE && !wr_done && busy0 && !valid0 && !done0 && rreg0 == 7) begin
                rf_we   = 1'b1;
                rf_wa   = 5'd7;
                rf_wd   = 32'hDEAD;
                wr_done = 1;
            end
            if (mode == MODE_BP && !bp_done && valid0 && daddr0 == 5) begin
                ready0 = 1'b0;
                repeat (3) begin
                    tick();
                    check("bp_valid", 32'(valid0), 1);
                    check("bp_addr", 32'(daddr0), 5);
                    check("bp_data", ddata0, 32'h105);
                end
                ready0  = 1'b1;
                bp_done = 1;
            end
            if (mode == MODE_RESET && valid0 && daddr0 == 12) begin
                rst = 1'b1;
                #1;
                check("rst_rreg", 32'(rreg0), 0);
                check("rst_ddata", ddata0, 0);
                check("rst_daddr", 32'(daddr0), 0);
                check("rst_valid", 32'(valid0), 0);
                check("rst_busy", 32'(busy0), 0);
                check("rst_done", 32'(done0), 0);
                q0.delete();
                tick();
                rst = 1'b0;
                tick();
                check("post_rst_busy", 32'(busy0), 0);
                check("post_rst_valid", 32'(valid0), 0);
                rst_done = 1;
            end
        end
        if (mode == MODE_RESET) begin
            check("rst_reached_beat12", 32'(rst_done), 1);
            q0.delete();
            return;
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done0_timeout: got no Done expected Done within 200 cycles");
            q0.delete();
            return;
        end
        check("done_cycle", done_cyc - e0, exp_len);
        tick();
        start0 = 1'b0;
        check("busy_after_done", 32'(busy0), 0);
        check("done_one_cycle", 32'(done0), 0);
        repeat (4) tick();
        check("idle_valid", 32'(valid0), 0);
        check("idle_busy", 32'(busy0), 0);
        check("beats_left0", q0.size(), 0);
        check("done_pulses0", done_cnt0 - dc_before, 1);
        q0.delete();
    endtask

    task automatic run_skip1();
        beat_t b;
        int    e0, done_cyc;
        bit    seen_valid, seen_done;
        seen_valid = 0; seen_done = 0; done_cyc = 0;
        for (int i = 1; i < 32; i++) begin
            b.addr = 5'(i);
            b.data = exp_regs[i];
            q1.push_back(b);
        end
        start1 = 1'b1;
        e0 = cyc + 1;
        for (int n = 0; n < 200 && !seen_done; n++) begin
            tick();
            start1 = 1'b0;
            if (n == 0) check("skip_start_rreg", 32'(rreg1), 1);
            if (!seen_valid && valid1) begin
                seen_valid = 1;
                check("skip_first_valid_latency", cyc - e0, 1);
            end
            if (done1) begin
                seen_done = 1;
                done_cyc  = cyc;
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done1_timeout: got no Done expected Done within 200 cycles");
            q1.delete();
            return;
        end
        check("skip_done_cycle", done_cyc - e0, 62);
        check("skip_last_addr", 32'(last_addr1), 31);
        check("skip_beats_left", q1.size(), 0);
        tick();
        check("skip_busy_after_done", 32'(busy1), 0);
        q1.delete();
    endtask

    initial begin
        rst     = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        ready0  = 1'b1;
        ready1  = 1'b1;
        rf_init = 1'b0;
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h100 + i;

        tick();
        check("reset_rreg", 32'(rreg0), 0);
        check("reset_ddata", ddata0, 0);
        check("reset_daddr", 32'(daddr0), 0);
        check("reset_valid", 32'(valid0), 0);
        check("reset_busy", 32'(busy0), 0);
        check("reset_done", 32'(done0), 0);
        check("reset_valid1", 32'(valid1), 0);

        rf_init = 1'b1;
        tick();
        rf_init = 1'b0;
        rst     = 1'b0;
        tick();

        run_dump0(MODE_NORMAL);
        run_skip1();
        run_dump0(MODE_BP);
        run_dump0(MODE_RESTART);
        run_dump0(MODE_RESET);
        run_dump0(MODE_NORMAL);
        run_dump0(MODE_WRITE);
        exp_regs[7] = 32'hDEAD;
        run_dump0(MODE_NORMAL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
